// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer.
// The optional MELODY_LOOP_EN build macro is consumed by melody_sequencer.
package melody_pkg;

  localparam int SCALE_W = 6;
  localparam int DUR_W   = 3;
  localparam int IDX_W   = 4;
  localparam int ROM_AW  = 2 + IDX_W;

  localparam logic [1:0] MEL_JUMP = 2'd0;
  localparam logic [1:0] MEL_LAND = 2'd1;
  localparam logic [1:0] MEL_OVER = 2'd2;
  localparam logic [1:0] MEL_BG   = 2'd3;

  localparam logic [SCALE_W-1:0] SCALE_REST = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_NOTE,
    ST_GAP,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [SCALE_W-1:0] scale;
    logic [DUR_W-1:0]   dur;
  } rom_entry_t;

  function automatic rom_entry_t make_entry(input logic [SCALE_W-1:0] scale,
                                            input logic [DUR_W-1:0]   dur);
    rom_entry_t e;
    e.scale = scale;
    e.dur   = dur;
    return e;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Melody table: 4 melodies x 16 entries of {scale, dur}, registered read.
// dur=0 marks the end of a melody; unlisted entries are end markers.
module melody_rom
  import melody_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROM_AW-1:0] addr,
  output rom_entry_t        rdata
);

  logic [1:0]       mel;
  logic [IDX_W-1:0] idx;
  rom_entry_t       word;

  assign mel = addr[ROM_AW-1:IDX_W];
  assign idx = addr[IDX_W-1:0];

  always_comb begin
    word = make_entry(SCALE_REST, '0);
    case (mel)
      MEL_JUMP: begin
        case (idx)
          4'd0:    word = make_entry(6'd5, 3'd1);
          4'd1:    word = make_entry(6'd9, 3'd2);
          default: ;
        endcase
      end
      // Land runs all 16 slots with no end marker: scales 1..16, one beat each.
      MEL_LAND: word = make_entry(SCALE_W'(idx) + SCALE_W'(1), 3'd1);
      MEL_OVER: begin
        case (idx)
          4'd0:    word = make_entry(6'd20, 3'd2);
          4'd1:    word = make_entry(6'd24, 3'd1);
          default: ;
        endcase
      end
      MEL_BG: begin
        case (idx)
          4'd0:    word = make_entry(6'd7, 3'd1);
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= make_entry(SCALE_REST, '0);
    else        rdata <= word;
  end

endmodule

// File: rtl/melody_sequencer.sv
// Plays ROM melodies as note codes for the buzzer. Build with MELODY_LOOP_EN
// to make the background melody (sel=3) loop until stopped or preempted.
//
// state | meaning
// IDLE  | silent, waiting for i_play
// FETCH | ROM entry valid; decide note or end (also the last gap cycle)
// NOTE  | sounding the note for dur*BEAT_CYCLES cycles
// GAP   | silence between notes
// DONE  | one-cycle o_done pulse, then IDLE
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_play,
  input  logic [1:0]         i_sel,
  input  logic               i_stop,
  output logic [SCALE_W-1:0] o_music_scale,
  output logic               o_busy,
  output logic               o_done
);

  localparam int CNT_W = $clog2(7 * BEAT_CYCLES + 1);
  localparam logic [CNT_W-1:0] BEAT_LEN = CNT_W'(BEAT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state_q;
  logic [1:0]       sel_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] note_load;
  logic [ROM_AW-1:0] rom_addr;
  rom_entry_t       rom_q;
  logic             loop_active;
  logic             last_entry;
  logic             start;

`ifdef MELODY_LOOP_EN
  assign loop_active = (sel_q == MEL_BG);
`else
  assign loop_active = 1'b0;
`endif

  assign start      = i_play && !i_stop;
  assign last_entry = (idx_q == '1) && !loop_active;
  assign note_load  = CNT_W'(rom_q.dur) * BEAT_LEN - ONE;
  assign o_busy     = (state_q != ST_IDLE);

  // The ROM is addressed with the index the FSM is about to enter, so the
  // entry is already registered during the single FETCH cycle.
  always_comb begin
    rom_addr = {sel_q, idx_q};
    if (start) begin
      rom_addr = {i_sel, IDX_W'(0)};
    end else if (state_q == ST_NOTE || state_q == ST_GAP) begin
      rom_addr = {sel_q, idx_q + IDX_W'(1)};
    end else if (state_q == ST_FETCH && rom_q.dur == '0 && loop_active) begin
      rom_addr = {sel_q, IDX_W'(0)};
    end
  end

  melody_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (rom_addr),
    .rdata (rom_q)
  );

  // The FETCH cycle doubles as the final silent gap cycle, so a gap is
  // GAP_CYCLES-1 cycles in GAP plus FETCH (all GAP_CYCLES in GAP after idx 15).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      o_music_scale <= SCALE_REST;
      o_done        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_stop && state_q != ST_IDLE) begin
        state_q       <= ST_IDLE;
        idx_q         <= '0;
        cnt_q         <= '0;
        o_music_scale <= SCALE_REST;
      end else if (start) begin
        state_q       <= ST_FETCH;
        sel_q         <= i_sel;
        idx_q         <= '0;
        cnt_q         <= '0;
        o_music_scale <= SCALE_REST;
      end else begin
        unique case (state_q)
          ST_IDLE: ;
          ST_FETCH: begin
            if (rom_q.dur != '0) begin
              state_q       <= ST_NOTE;
              o_music_scale <= rom_q.scale;
              cnt_q         <= note_load;
            end else if (loop_active) begin
              idx_q <= '0;
            end else begin
              state_q <= ST_DONE;
              o_done  <= 1'b1;
            end
          end
          ST_NOTE: begin
            if (cnt_q == '0) begin
              o_music_scale <= SCALE_REST;
              cnt_q         <= GAP_LOAD;
              if (GAP_CYCLES == 1 && !last_entry) begin
                idx_q   <= idx_q + IDX_W'(1);
                state_q <= ST_FETCH;
              end else begin
                state_q <= ST_GAP;
              end
            end else begin
              cnt_q <= cnt_q - ONE;
            end
          end
          ST_GAP: begin
            if (cnt_q == '0) begin
              state_q <= ST_DONE;
              o_done  <= 1'b1;
            end else if (cnt_q == ONE && !last_entry) begin
              idx_q   <= idx_q + IDX_W'(1);
              cnt_q   <= '0;
              state_q <= ST_FETCH;
            end else begin
              cnt_q <= cnt_q - ONE;
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer (BEAT_CYCLES=4, GAP_CYCLES=1).
// Expected output events are queued by the stimulus and popped by a monitor.
module tb_melody_sequencer;

  localparam int BEAT = 4;
  localparam int GAP  = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_play;
  logic [1:0] i_sel;
  logic       i_stop;
  logic [5:0] o_music_scale;
  logic       o_busy;
  logic       o_done;

  melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_play        (i_play),
    .i_sel         (i_sel),
    .i_stop        (i_stop),
    .o_music_scale (o_music_scale),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0] scale;
    logic       done;
    int         t;
  } ev_t;

  ev_t        exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [5:0] prev_scale = 6'd0;

  function automatic void exp_ev(input logic [5:0] s, input logic d, input int t);
    ev_t e;
    e.scale = s;
    e.done  = d;
    e.t     = t;
    exp_q.push_back(e);
  endfunction

  // An output event is any change of o_music_scale or an o_done pulse.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (o_music_scale !== prev_scale || o_done === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: cyc=%0d scale=%0d done=%0b, required no event",
                 cyc, o_music_scale, o_done);
      end else begin
        e = exp_q.pop_front();
        if (o_music_scale !== e.scale || o_done !== e.done || cyc != e.t) begin
          n_err++;
          $display("FAIL event: got scale=%0d done=%0b cyc=%0d, required scale=%0d done=%0b cyc=%0d",
                   o_music_scale, o_done, cyc, e.scale, e.done, e.t);
        end
      end
    end
    prev_scale = o_music_scale;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (cyc=%0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic play(input logic [1:0] s, output int p);
    @(posedge clk);
    #1;
    i_sel  = s;
    i_play = 1'b1;
    p      = cyc;
    @(posedge clk);
    #1;
    i_play = 1'b0;
  endtask

  initial begin
    int p;
    int q;
    rst_n  = 1'b0;
    i_play = 1'b0;
    i_stop = 1'b0;
    i_sel  = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_scale", 8'(o_music_scale), 8'd0);
    check("reset_busy", 8'(o_busy), 8'd0);
    check("reset_done", 8'(o_done), 8'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_reset", 8'(o_busy), 8'd0);

    // Basic playback of melody 0: (5,1),(9,2),end
    play(2'd0, p);
    exp_ev(6'd5, 1'b0, p + 2);
    exp_ev(6'd0, 1'b0, p + 6);
    exp_ev(6'd9, 1'b0, p + 7);
    exp_ev(6'd0, 1'b0, p + 15);
    exp_ev(6'd0, 1'b1, p + 16);
    wait_to(p + 16);
    check("basic_busy_in_done", 8'(o_busy), 8'd1);
    wait_to(p + 17);
    check("basic_busy_after", 8'(o_busy), 8'd0);
    wait_to(p + 20);

    // Preemption: melody 2 replaces melody 0 mid-note, no done for melody 0
    play(2'd0, p);
    exp_ev(6'd5, 1'b0, p + 2);
    wait_to(p + 2);
    play(2'd2, q);
    exp_ev(6'd0, 1'b0, q + 1);
    exp_ev(6'd20, 1'b0, q + 2);
    exp_ev(6'd0, 1'b0, q + 10);
    exp_ev(6'd24, 1'b0, q + 11);
    exp_ev(6'd0, 1'b0, q + 15);
    exp_ev(6'd0, 1'b1, q + 16);
    wait_to(q + 20);
    check("preempt_idle", 8'(o_busy), 8'd0);

    // Stop and play together: stop wins, nothing restarts
    play(2'd1, p);
    exp_ev(6'd1, 1'b0, p + 2);
    exp_ev(6'd0, 1'b0, p + 6);
    wait_to(p + 4);
    @(posedge clk);
    #1;
    i_stop = 1'b1;
    i_play = 1'b1;
    i_sel  = 2'd0;
    @(posedge clk);
    #1;
    i_stop = 1'b0;
    i_play = 1'b0;
    check("stop_scale", 8'(o_music_scale), 8'd0);
    check("stop_busy", 8'(o_busy), 8'd0);
    wait_to(p + 20);
    check("stop_no_restart", 8'(o_busy), 8'd0);

    // Full 16-entry melody without end marker
    play(2'd1, p);
    for (int k = 0; k < 16; k++) begin
      exp_ev(6'(k + 1), 1'b0, p + 2 + 5 * k);
      exp_ev(6'd0, 1'b0, p + 6 + 5 * k);
    end
    exp_ev(6'd0, 1'b1, p + 82);
    wait_to(p + 82);
    check("full_busy_in_done", 8'(o_busy), 8'd1);
    wait_to(p + 83);
    check("full_busy_after", 8'(o_busy), 8'd0);
    wait_to(p + 86);

    // Melody 3: (7,1),end
    play(2'd3, p);
    exp_ev(6'd7, 1'b0, p + 2);
    exp_ev(6'd0, 1'b0, p + 6);
`ifdef MELODY_LOOP_EN
    exp_ev(6'd7, 1'b0, p + 8);
    exp_ev(6'd0, 1'b0, p + 12);
    exp_ev(6'd7, 1'b0, p + 14);
    exp_ev(6'd0, 1'b0, p + 18);
    exp_ev(6'd7, 1'b0, p + 20);
    exp_ev(6'd0, 1'b0, p + 22);
    wait_to(p + 20);
    @(posedge clk);
    #1;
    i_stop = 1'b1;
    @(posedge clk);
    #1;
    i_stop = 1'b0;
    check("loop_stop_busy", 8'(o_busy), 8'd0);
    wait_to(p + 30);
`else
    exp_ev(6'd0, 1'b1, p + 7);
    wait_to(p + 8);
    check("bg_busy_after", 8'(o_busy), 8'd0);
    wait_to(p + 12);
`endif

    // Asynchronous reset in the middle of a note
    play(2'd0, p);
    exp_ev(6'd5, 1'b0, p + 2);
    exp_ev(6'd0, 1'b0, p + 3);
    wait_to(p + 3);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_scale", 8'(o_music_scale), 8'd0);
    check("async_rst_busy", 8'(o_busy), 8'd0);
    wait_to(p + 6);
    rst_n = 1'b1;
    wait_to(p + 14);
    check("post_rst_idle", 8'(o_busy), 8'd0);
    check("post_rst_scale", 8'(o_music_scale), 8'd0);

    repeat (4) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_event: got none, required scale=%0d done=%0b cyc=%0d",
               e.scale, e.done, e.t);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
